// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage.
// Consumes the registered execute-stage outputs, performs byte-lane-correct
// loads and stores on a valid/ready data-memory port and presents the
// writeback result.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in*                 execute-stage result interface (valid, ALU result /
//                       effective address, store data, load/store controls)
//   outStall            combinational hold request to the execute stage
//   memReq*             data-memory request (valid/ready, dword address,
//                       write flag, lane-replicated data, byte strobes)
//   memResp*            data-memory response/ack and load doubleword
//   out*                writeback interface (one-cycle outValid pulse)
module mem_stage #(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    input  logic [BUS_DATA_WIDTH-1:0] inResult,
    input  logic [BUS_DATA_WIDTH-1:0] inDataReg2,
    input  logic                      inMemRead,
    input  logic                      inMemWrite,
    input  logic                      inRegWrite,
    input  logic [4:0]                inDestRegister,
    input  logic [2:0]                inLoadType,
    input  logic [1:0]                inStoreType,
    output logic                      outStall,
    output logic                      memReqValid,
    input  logic                      memReqReady,
    output logic [BUS_DATA_WIDTH-1:0] memReqAddr,
    output logic                      memReqWrite,
    output logic [BUS_DATA_WIDTH-1:0] memReqWdata,
    output logic [7:0]                memReqWstrb,
    input  logic                      memRespValid,
    input  logic [BUS_DATA_WIDTH-1:0] memRespRdata,
    output logic                      outValid,
    output logic [BUS_DATA_WIDTH-1:0] outResult,
    output logic                      outRegWrite,
    output logic [4:0]                outDestRegister,
    output logic                      outMisaligned
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state, state_next;

    logic [2:0]  off;
    logic [1:0]  size_log2;
    logic        memop;
    logic        misaligned;
    logic        capture;
    logic [63:0] wdata_d;
    logic [7:0]  wstrb_d;

    // Captured transaction
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        write_q;
    logic [2:0]  ltype_q;
    logic [4:0]  rd_q;
    logic        rw_q;

    // Next values of the writeback registers
    logic        valid_d;
    logic [63:0] result_d;
    logic        rw_d;
    logic [4:0]  rd_d;
    logic        mis_d;

    logic [63:0] lanes;
    logic [63:0] load_value;

    assign off   = inResult[2:0];
    assign memop = inMemRead | inMemWrite;

    // A store wins when both read and write are flagged.
    always_comb begin
        size_log2 = inMemWrite ? inStoreType : inLoadType[1:0];
        case (size_log2)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = |off[1:0];
            default: misaligned = |off;
        endcase
        misaligned = misaligned & memop;
    end

    assign capture = (state == IDLE) & inValid & memop & ~misaligned;

    always_comb begin
        case (inStoreType)
            2'd0: begin
                wdata_d = {8{inDataReg2[7:0]}};
                wstrb_d = 8'h01 << off;
            end
            2'd1: begin
                wdata_d = {4{inDataReg2[15:0]}};
                wstrb_d = 8'h03 << off;
            end
            2'd2: begin
                wdata_d = {2{inDataReg2[31:0]}};
                wstrb_d = 8'h0F << off;
            end
            default: begin
                wdata_d = inDataReg2;
                wstrb_d = 8'hFF;
            end
        endcase
    end

    // Bring the addressed bytes down to lane 0, then extend.
    always_comb begin
        lanes = memRespRdata >> {addr_q[2:0], 3'b000};
        case (ltype_q)
            3'b000:  load_value = {{56{lanes[7]}}, lanes[7:0]};
            3'b001:  load_value = {{48{lanes[15]}}, lanes[15:0]};
            3'b010:  load_value = {{32{lanes[31]}}, lanes[31:0]};
            3'b100:  load_value = {56'd0, lanes[7:0]};
            3'b101:  load_value = {48'd0, lanes[15:0]};
            3'b110:  load_value = {32'd0, lanes[31:0]};
            default: load_value = lanes;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (capture) state_next = REQ;
            REQ:     if (memReqReady) state_next = RESP;
            RESP:    if (memRespValid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs (stall and next writeback values)
    always_comb begin
        outStall = 1'b0;
        valid_d  = 1'b0;
        result_d = outResult;
        rw_d     = outRegWrite;
        rd_d     = outDestRegister;
        mis_d    = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    outStall = 1'b1;
                end else if (inValid) begin
                    valid_d  = 1'b1;
                    result_d = inResult;
                    rw_d     = inRegWrite & ~misaligned;
                    rd_d     = inDestRegister;
                    mis_d    = misaligned;
                end
            end
            REQ: outStall = 1'b1;
            RESP: begin
                if (memRespValid) begin
                    valid_d  = 1'b1;
                    result_d = write_q ? 64'd0 : load_value;
                    rw_d     = rw_q & ~write_q;
                    rd_d     = rd_q;
                end else begin
                    outStall = 1'b1;
                end
            end
            default: outStall = 1'b0;
        endcase
    end

    assign memReqValid = (state == REQ);
    assign memReqAddr  = {addr_q[63:3], 3'b000};
    assign memReqWrite = write_q;
    assign memReqWdata = wdata_q;
    assign memReqWstrb = wstrb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            write_q         <= 1'b0;
            ltype_q         <= '0;
            rd_q            <= '0;
            rw_q            <= 1'b0;
            outValid        <= 1'b0;
            outResult       <= '0;
            outRegWrite     <= 1'b0;
            outDestRegister <= '0;
            outMisaligned   <= 1'b0;
        end else begin
            if (capture) begin
                addr_q  <= inResult;
                wdata_q <= wdata_d;
                wstrb_q <= wstrb_d;
                write_q <= inMemWrite;
                ltype_q <= inLoadType;
                rd_q    <= inDestRegister;
                rw_q    <= inRegWrite;
            end
            outValid        <= valid_d;
            outResult       <= result_d;
            outRegWrite     <= rw_d;
            outDestRegister <= rd_d;
            outMisaligned   <= mis_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. A driver issues instructions
// and pushes expected writeback results and bus requests; a memory responder
// and a writeback monitor pop and compare.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic [63:0] inResult;
    logic [63:0] inDataReg2;
    logic        inMemRead;
    logic        inMemWrite;
    logic        inRegWrite;
    logic [4:0]  inDestRegister;
    logic [2:0]  inLoadType;
    logic [1:0]  inStoreType;
    logic        outStall;
    logic        memReqValid;
    logic        memReqReady;
    logic [63:0] memReqAddr;
    logic        memReqWrite;
    logic [63:0] memReqWdata;
    logic [7:0]  memReqWstrb;
    logic        memRespValid;
    logic [63:0] memRespRdata;
    logic        outValid;
    logic [63:0] outResult;
    logic        outRegWrite;
    logic [4:0]  outDestRegister;
    logic        outMisaligned;

    mem_stage #(.BUS_DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inResult(inResult),
        .inDataReg2(inDataReg2), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .inRegWrite(inRegWrite), .inDestRegister(inDestRegister),
        .inLoadType(inLoadType), .inStoreType(inStoreType), .outStall(outStall),
        .memReqValid(memReqValid), .memReqReady(memReqReady),
        .memReqAddr(memReqAddr), .memReqWrite(memReqWrite),
        .memReqWdata(memReqWdata), .memReqWstrb(memReqWstrb),
        .memRespValid(memRespValid), .memRespRdata(memRespRdata),
        .outValid(outValid), .outResult(outResult), .outRegWrite(outRegWrite),
        .outDestRegister(outDestRegister), .outMisaligned(outMisaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] result;
        logic        rw;
        logic [4:0]  rd;
        logic        mis;
    } wb_t;

    typedef struct {
        logic [63:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];

    int total = 0;
    int bad   = 0;

    logic [7:0]  ref_mem [256];   // byte-level reference memory
    logic [63:0] dmem [32];       // the memory device seen by the DUT

    int ready_delay = -1;
    int resp_delay  = -1;
    bit resp_hold   = 0;
    bit stray_now   = 0;
    bit awaiting    = 0;
    int last_req_cycles = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    task automatic preload(input int idx, input logic [63:0] v);
        dmem[idx] = v;
        for (int b = 0; b < 8; b++) ref_mem[idx*8+b] = v[8*b +: 8];
    endtask

    function automatic logic [63:0] load_ref(input logic [63:0] a, input int n, input bit sgn);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(int'(a[7:0]) + k) % 256];
        if (sgn && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    task automatic issue(input logic [63:0] res, input logic [63:0] data,
                         input logic rd_f, input logic wr_f, input logic rw,
                         input logic [4:0] rd, input logic [2:0] lt, input logic [1:0] st);
        int   n;
        int   off;
        bit   memop;
        bit   mis;
        bit   s;
        bit   first;
        int   guard;
        wb_t  w;
        req_t r;
        @(negedge clk);
        inValid = 1'b1; inResult = res; inDataReg2 = data; inMemRead = rd_f;
        inMemWrite = wr_f; inRegWrite = rw; inDestRegister = rd;
        inLoadType = lt; inStoreType = st;
        memop = rd_f | wr_f;
        off   = int'(res[2:0]);
        n     = wr_f ? (1 << st) : (1 << lt[1:0]);
        mis   = memop && (off % n != 0);
        w.rd  = rd;
        w.mis = mis;
        if (!memop || mis) begin
            w.result = res;
            w.rw     = rw & !mis;
        end else if (wr_f) begin
            w.result = '0;
            w.rw     = 1'b0;
            r.addr   = {res[63:3], 3'b000};
            r.write  = 1'b1;
            r.wstrb  = 8'(((1 << n) - 1) << off);
            for (int i = 0; i < 8; i++) r.wdata[8*i +: 8] = data[8*(i % n) +: 8];
            for (int k = 0; k < n; k++) ref_mem[(int'(res[7:0]) + k) % 256] = data[8*k +: 8];
            req_q.push_back(r);
        end else begin
            w.result = load_ref(res, n, !lt[2]);
            w.rw     = rw;
            r.addr   = {res[63:3], 3'b000};
            r.write  = 1'b0;
            r.wdata  = '0;
            r.wstrb  = '0;
            req_q.push_back(r);
        end
        wb_q.push_back(w);
        first = 1;
        guard = 0;
        forever begin
            #2;
            s = outStall;
            if (first) begin
                check("stall_first", {63'd0, s}, {63'd0, memop && !mis});
                first = 0;
            end
            @(posedge clk);
            if (!s) break;
            guard++;
            if (guard > 200) begin
                fail("stall_timeout");
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            inValid = 1'b0; inMemRead = 1'b0; inMemWrite = 1'b0;
            @(posedge clk);
        end
    endtask

    // Writeback monitor
    initial begin
        wb_t w;
        forever begin
            @(negedge clk);
            if (!reset && outValid) begin
                if (wb_q.size() == 0) begin
                    fail("unexpected_outValid");
                end else begin
                    w = wb_q.pop_front();
                    check("outResult", outResult, w.result);
                    check("outRegWrite", {63'd0, outRegWrite}, {63'd0, w.rw});
                    check("outDestRegister", {59'd0, outDestRegister}, {59'd0, w.rd});
                    check("outMisaligned", {63'd0, outMisaligned}, {63'd0, w.mis});
                end
            end
        end
    end

    // Memory responder
    initial begin
        int          cnt;
        int          req_cycles;
        logic [63:0] resp_data;
        req_t        first_req;
        req_t        e;
        bit          rdy;
        memReqReady  = 1'b0;
        memRespValid = 1'b0;
        memRespRdata = '0;
        cnt = 0; req_cycles = 0; resp_data = '0;
        forever begin
            @(negedge clk);
            memRespValid = 1'b0;
            memReqReady  = 1'b0;
            memRespRdata = {$urandom, $urandom};
            if (reset) begin
                awaiting   = 0;
                req_cycles = 0;
                continue;
            end
            if (awaiting) begin
                memReqReady = 1'($urandom_range(0, 1));
                check("req_dropped", {63'd0, memReqValid}, 64'd0);
                if (!resp_hold && cnt == 0) begin
                    memRespValid = 1'b1;
                    memRespRdata = resp_data;
                    awaiting     = 0;
                    #2 check("stall_resp_cycle", {63'd0, outStall}, 64'd0);
                end else begin
                    if (cnt > 0) cnt--;
                    #2 check("stall_waiting", {63'd0, outStall}, 64'd1);
                end
            end else if (memReqValid) begin
                if (req_cycles == 0) begin
                    first_req.addr  = memReqAddr;
                    first_req.write = memReqWrite;
                    first_req.wdata = memReqWdata;
                    first_req.wstrb = memReqWstrb;
                end else begin
                    check("req_addr_stable", memReqAddr, first_req.addr);
                    check("req_wdata_stable", memReqWdata, first_req.wdata);
                    check("req_ctl_stable", {55'd0, memReqWrite, memReqWstrb},
                          {55'd0, first_req.write, first_req.wstrb});
                end
                req_cycles++;
                if ($urandom_range(0, 3) == 0) memRespValid = 1'b1;
                rdy = (ready_delay < 0) ? ($urandom_range(0, 2) != 0) : (req_cycles > ready_delay);
                memReqReady = rdy;
                if (rdy) begin
                    if (req_q.size() == 0) begin
                        fail("unexpected_request");
                        resp_data = '0;
                    end else begin
                        e = req_q.pop_front();
                        check("req_addr", memReqAddr, e.addr);
                        check("req_write", {63'd0, memReqWrite}, {63'd0, e.write});
                        if (e.write) begin
                            check("req_wdata", memReqWdata, e.wdata);
                            check("req_wstrb", {56'd0, memReqWstrb}, {56'd0, e.wstrb});
                        end
                    end
                    if (memReqWrite) begin
                        for (int b = 0; b < 8; b++)
                            if (memReqWstrb[b]) dmem[memReqAddr[7:3]][8*b +: 8] = memReqWdata[8*b +: 8];
                        resp_data = {$urandom, $urandom};
                    end else begin
                        resp_data = dmem[memReqAddr[7:3]];
                    end
                    cnt = (resp_delay < 0) ? $urandom_range(0, 3) : resp_delay;
                    awaiting        = 1;
                    last_req_cycles = req_cycles;
                    req_cycles      = 0;
                end
            end else begin
                memReqReady = 1'($urandom_range(0, 1));
                if (stray_now || $urandom_range(0, 7) == 0) memRespValid = 1'b1;
                stray_now = 0;
            end
        end
    end

    // Stimulus
    initial begin
        logic [63:0] a;
        int          kind;
        int          guard;
        reset = 1'b1;
        inValid = 1'b0; inResult = '0; inDataReg2 = '0; inMemRead = 1'b0;
        inMemWrite = 1'b0; inRegWrite = 1'b0; inDestRegister = '0;
        inLoadType = '0; inStoreType = '0;
        for (int i = 0; i < 32; i++) preload(i, {$urandom, $urandom});
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outValid", {63'd0, outValid}, 64'd0);
        check("rst_outResult", outResult, 64'd0);
        check("rst_outRegWrite", {63'd0, outRegWrite}, 64'd0);
        check("rst_outDest", {59'd0, outDestRegister}, 64'd0);
        check("rst_outMisaligned", {63'd0, outMisaligned}, 64'd0);
        check("rst_memReqValid", {63'd0, memReqValid}, 64'd0);
        check("rst_outStall", {63'd0, outStall}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Pass-through ALU op
        issue(64'h1234, 64'd0, 0, 0, 1, 5'd5, 3'b000, 2'b00);
        idle(1);

        // lb / lbu sign and zero extension
        preload(0, 64'h0000_0000_8000_0000);
        issue(64'h1003, 64'd0, 1, 0, 1, 5'd3, 3'b000, 2'b00);
        issue(64'h1003, 64'd0, 1, 0, 1, 5'd4, 3'b100, 2'b00);

        // sh store into the top halfword
        issue(64'h2006, 64'hABCD, 0, 1, 1, 5'd6, 3'b000, 2'b01);

        // Backpressure: ready held low 3 cycles, response 2 cycles later
        ready_delay = 3;
        resp_delay  = 2;
        issue(64'h48, 64'd0, 1, 0, 1, 5'd9, 3'b011, 2'b00);
        check("req_valid_cycles", 64'(last_req_cycles), 64'd4);
        ready_delay = -1;
        resp_delay  = -1;

        // Misaligned lw, and read+write treated as store
        issue(64'h3002, 64'd0, 1, 0, 1, 5'd10, 3'b010, 2'b00);
        issue(64'h10, 64'h1122_3344_5566_7788, 1, 1, 1, 5'd11, 3'b000, 2'b10);
        issue(64'h14, 64'd0, 1, 0, 1, 5'd12, 3'b110, 2'b00);
        idle(2);

        // Randomized mix
        for (int t = 0; t < 300; t++) begin
            a = {$urandom, $urandom};
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 0) a[2:0] = 3'b000;
            if (kind == 0)
                issue(a, {$urandom, $urandom}, 0, 0, 1'($urandom), 5'($urandom), 3'($urandom), 2'($urandom));
            else if (kind == 1)
                issue(a, {$urandom, $urandom}, 1, 0, 1'($urandom), 5'($urandom),
                      3'($urandom_range(0, 6)), 2'($urandom));
            else
                issue(a, {$urandom, $urandom}, 1'($urandom), 1, 1'($urandom), 5'($urandom),
                      3'($urandom), 2'($urandom));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        // Reset while waiting for a response, then a stray response
        resp_hold = 1;
        req_q.push_back('{addr: 64'h40, write: 1'b0, wdata: 64'd0, wstrb: 8'd0});
        @(negedge clk);
        inValid = 1'b1; inResult = 64'h40; inMemRead = 1'b1; inMemWrite = 1'b0;
        inRegWrite = 1'b1; inDestRegister = 5'd7; inLoadType = 3'b011;
        guard = 0;
        while (!awaiting && guard < 50) begin
            @(negedge clk); #3;
            guard++;
        end
        if (!awaiting) fail("reset_test_no_handshake");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        inValid = 1'b0; inMemRead = 1'b0;
        @(negedge clk); #2;
        check("rst_mid_memReqValid", {63'd0, memReqValid}, 64'd0);
        check("rst_mid_outStall", {63'd0, outStall}, 64'd0);
        check("rst_mid_outResult", outResult, 64'd0);
        check("rst_mid_outRegWrite", {63'd0, outRegWrite}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        resp_hold = 0;
        stray_now = 1;
        repeat (4) @(posedge clk);
        @(negedge clk); #2;
        check("post_stray_memReqValid", {63'd0, memReqValid}, 64'd0);
        check("post_stray_outStall", {63'd0, outStall}, 64'd0);
        idle(2);

        check("wb_queue_empty", 64'(wb_q.size()), 64'd0);
        check("req_queue_empty", 64'(req_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory-access stage. It is the consumer end of the execute-stage result interface.
- Takes the registered execute outputs (ALU result/address, store data, load/store type, writeback controls) and performs byte-lane–correct loads and stores on a valid/ready data-memory port.
- Presents the writeback result to the WB stage.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- BUS_DATA_WIDTH, 64, width of data, address and result paths. Only 64 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- inValid  in  1  execute stage presents an instruction this cycle
- inResult  in  BUS_DATA_WIDTH  ALU result; this is the effective address for memory ops
- inDataReg2  in  BUS_DATA_WIDTH  store data (rs2)
- inMemRead  in  1  instruction is a load
- inMemWrite  in  1  instruction is a store
- inRegWrite  in  1  instruction writes rd
- inDestRegister  in  5  rd index
- inLoadType  in  3  000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
- inStoreType  in  2  00 sb, 01 sh, 10 sw, 11 sd
- outStall  out  1  hold execute-stage outputs; combinational
- memReqValid  out  1  data-memory request valid
- memReqReady  in  1  memory accepts request
- memReqAddr  out  BUS_DATA_WIDTH  doubleword-aligned address {addr[63:3],3'b000}
- memReqWrite  out  1  1 = store, 0 = load
- memReqWdata  out  BUS_DATA_WIDTH  lane-replicated store data
- memReqWstrb  out  8  byte strobes
- memRespValid  in  1  response/ack valid (returned for loads and stores)
- memRespRdata  in  BUS_DATA_WIDTH  load doubleword
- outValid  out  1  one-cycle writeback pulse
- outResult  out  BUS_DATA_WIDTH  writeback value
- outRegWrite  out  1  writeback enable
- outDestRegister  out  5  rd
- outMisaligned  out  1  one-cycle pulse with outValid for a misaligned access

Behaviour:
- Reset value of every output register is 0. FSM resets to IDLE, memReqValid=0, outStall=0.
- "memop" means inMemRead|inMemWrite. Let off=inResult[2:0].
- Misalignment rules:
  - h accesses require off[0]=0.
  - w accesses require off[1:0]=0.
  - d accesses require off=0.
  - b accesses are always aligned.
- An input is consumed on any rising edge where inValid=1 and outStall=0, or on the capture edge in IDLE.
- FSM states: IDLE, REQ, RESP.
- IDLE, non-memop (or misaligned memop):
  - Next cycle outValid=1 and outResult=inResult.
  - outRegWrite = inRegWrite & !misaligned; outDestRegister=inDestRegister.
  - outMisaligned=misaligned.
  - No bus request and no stall. Latency is 1 cycle.
- IDLE, aligned memop:
  - outStall=1 this cycle.
  - Capture address, store data, type, rd and regWrite.
  - Go to REQ.
- REQ:
  - memReqValid=1; address, write, wdata and wstrb are held stable; outStall=1.
  - When memReqReady=1, go to RESP. memReqValid drops the following cycle.
- RESP:
  - outStall=1 until memRespValid=1. In the memRespValid cycle outStall=0, so upstream advances on that edge.
  - On that edge go to IDLE and register outValid=1.
  - Loads: outResult is the selected lanes of memRespRdata starting at byte off, sign-extended (lb/lh/lw) or zero-extended (lbu/lhu/lwu, ld raw). outRegWrite = captured regWrite.
  - Stores: outResult=0, outRegWrite=0.
- Minimum load latency, with ready and response immediate: present at cycle 0, REQ at cycle 1, RESP at cycle 2, outValid at cycle 3.
- Store strobes and data:
  - sb: wstrb=8'h01<<off, wdata=byte replicated 8x.
  - sh: wstrb=8'h03<<off, wdata=halfword replicated 4x.
  - sw: wstrb=8'h0F<<off, wdata=word replicated 2x.
  - sd: wstrb=8'hFF, wdata=data.
- outValid is 0 in all cycles other than those listed above. Outputs other than outValid hold their last values.
- Boundary conditions:
  - memRespValid in IDLE or REQ is ignored.
  - memReqReady outside REQ is ignored.
  - inMemRead and inMemWrite both set is treated as a store.
  - Back-to-back memops: the next op is captured in IDLE the cycle after RESP completes.
  - Reset mid-operation (REQ or RESP) returns immediately to IDLE, drops memReqValid and outStall, and clears outputs. A later stray response is ignored.

Test Plan:
- Pass-through: ALU op, inResult=64'h1234, inRegWrite=1, rd=5 -> next cycle outValid=1, outResult=64'h1234, outRegWrite=1, outDestRegister=5, outStall never 1.
- lb sign extension: addr=64'h1003, memRespRdata=64'h0000_0000_8000_0000 -> memReqAddr=64'h1000, memReqWrite=0, outResult=64'hFFFF_FFFF_FFFF_FF80. Repeated as lbu -> outResult=64'h80.
- sh store: addr=64'h2006, data=64'hABCD -> memReqWstrb=8'hC0, memReqWdata=64'hABCD_ABCD_ABCD_ABCD, outRegWrite=0.
- Backpressure: memReqReady low for 3 cycles, response 2 cycles later -> memReqValid held 4 cycles with stable fields, outStall held until the response cycle, exactly one outValid pulse.
- Misaligned lw at addr=64'h3002 -> no memReqValid, next cycle outValid=1, outMisaligned=1, outRegWrite=0.
- Reset asserted in RESP, then a stray memRespValid after release -> memReqValid=0, outStall=0, no outValid pulse.
